// File: rtl/ledg_seq_pkg.sv
// Shared definitions for the LED sequencer: CSR word map, CTRL/STATUS bit
// positions and the playback FSM encoding.
package ledg_seq_pkg;

    localparam logic [3:0] ADDR_CTRL         = 4'd0;
    localparam logic [3:0] ADDR_DWELL        = 4'd1;
    localparam logic [3:0] ADDR_LENGTH       = 4'd2;
    localparam logic [3:0] ADDR_STATUS       = 4'd3;
    localparam logic [3:0] ADDR_DIRECT       = 4'd4;
    localparam logic [3:0] ADDR_PATTERN_BASE = 4'd8;

    // CTRL bit 0 is start on write and busy on read.
    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_STOP   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STATUS_DONE    = 0;
    localparam int STATUS_IDX_LSB = 4;
    localparam int IDX_WIDTH      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT
    } state_t;

    // A programmed length of 0, or one beyond the table, plays the whole table.
    function automatic logic [3:0] eff_length(input logic [3:0] length, input logic [3:0] depth);
        return (length == 4'd0 || length > depth) ? depth : length;
    endfunction

endpackage

// File: rtl/ledg_seq_csr.sv
// CSR slave of the LED sequencer: register file, pattern table, combinational
// read mux and the single-cycle start/stop/direct command pulses.
module ledg_seq_csr
    import ledg_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             s_address,
    input  logic                   s_chipselect,
    input  logic                   s_write_n,
    input  logic [31:0]            s_writedata,
    output logic [31:0]            s_readdata,
    input  logic                   busy,
    input  logic [IDX_WIDTH-1:0]   idx,
    input  logic                   done_set,
    input  logic                   done_clr,
    input  logic [IDX_WIDTH-1:0]   pattern_idx,
    output logic [DATA_WIDTH-1:0]  pattern_data,
    output logic                   start,
    output logic                   stop,
    output logic                   direct,
    output logic [DATA_WIDTH-1:0]  direct_data,
    output logic                   loop,
    output logic                   irq_en,
    output logic [DWELL_WIDTH-1:0] dwell,
    output logic [3:0]             length,
    output logic                   done
);

    logic [DATA_WIDTH-1:0] pattern [DEPTH];
    logic                  wr;
    logic                  pattern_hit;
    logic                  unused_wdata;

    assign wr          = s_chipselect & ~s_write_n;
    assign pattern_hit = ({1'b0, s_address} >= 5'(ADDR_PATTERN_BASE)) &&
                         ({1'b0, s_address} <  5'(ADDR_PATTERN_BASE) + 5'(DEPTH));

    assign start        = wr && (s_address == ADDR_CTRL) && s_writedata[CTRL_START];
    assign stop         = wr && (s_address == ADDR_CTRL) && s_writedata[CTRL_STOP];
    assign direct       = wr && (s_address == ADDR_DIRECT);
    assign direct_data  = s_writedata[DATA_WIDTH-1:0];
    assign pattern_data = pattern[pattern_idx];
    assign unused_wdata = ^s_writedata[31:DWELL_WIDTH];

    // NOTE: the pattern table lives in flops, so it is cleared on reset like
    // every other register instead of being left with power-up contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop   <= 1'b0;
            irq_en <= 1'b0;
            dwell  <= '0;
            length <= '0;
            done   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        end else begin
            if (wr && s_address == ADDR_CTRL) begin
                loop   <= s_writedata[CTRL_LOOP];
                irq_en <= s_writedata[CTRL_IRQ_EN];
            end
            if (wr && s_address == ADDR_DWELL) dwell <= s_writedata[DWELL_WIDTH-1:0];
            if (wr && s_address == ADDR_LENGTH && !busy) length <= s_writedata[3:0];
            if (wr && pattern_hit) pattern[s_address[2:0]] <= s_writedata[DATA_WIDTH-1:0];
            // A hardware completion outranks a same-cycle software clear.
            if (done_set)
                done <= 1'b1;
            else if (done_clr || (wr && s_address == ADDR_STATUS && s_writedata[STATUS_DONE]))
                done <= 1'b0;
        end
    end

    always_comb begin
        s_readdata = '0;
        if (pattern_hit) begin
            s_readdata[DATA_WIDTH-1:0] = pattern[s_address[2:0]];
        end else begin
            case (s_address)
                ADDR_CTRL: begin
                    s_readdata[CTRL_BUSY]   = busy;
                    s_readdata[CTRL_LOOP]   = loop;
                    s_readdata[CTRL_IRQ_EN] = irq_en;
                end
                ADDR_DWELL:  s_readdata[DWELL_WIDTH-1:0] = dwell;
                ADDR_LENGTH: s_readdata[3:0] = length;
                ADDR_STATUS: begin
                    s_readdata[STATUS_DONE] = done;
                    s_readdata[STATUS_IDX_LSB +: IDX_WIDTH] = idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ledg_sequencer.sv
// Avalon-MM LED sequencer: plays a CSR-loaded pattern table into the green-LED
// PIO at a programmable dwell, and forwards direct LED writes while idle.
module ledg_sequencer
    import ledg_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int DWELL_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy,
    output logic        irq
);

    state_t                 state, state_next;
    logic [IDX_WIDTH-1:0]   idx, idx_next;
    logic [DWELL_WIDTH-1:0] cnt, cnt_next, dwell_eff;
    logic [DATA_WIDTH-1:0]  led;
    logic                   load_next, direct_next, last;

    logic                   start, stop, direct, loop, irq_en, done, done_set, done_clr;
    logic [DATA_WIDTH-1:0]  direct_data, pattern_data;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [3:0]             length;

    ledg_seq_csr #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_csr (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .busy         (busy),
        .idx          (idx),
        .done_set     (done_set),
        .done_clr     (done_clr),
        .pattern_idx  (idx_next),
        .pattern_data (pattern_data),
        .start        (start),
        .stop         (stop),
        .direct       (direct),
        .direct_data  (direct_data),
        .loop         (loop),
        .irq_en       (irq_en),
        .dwell        (dwell),
        .length       (length),
        .done         (done)
    );

    assign dwell_eff = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
    assign last      = ({1'b0, idx} + 4'd1) >= eff_length(length, 4'(DEPTH));

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        cnt_next    = cnt;
        load_next   = 1'b0;
        direct_next = 1'b0;
        done_set    = 1'b0;
        done_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                    load_next  = 1'b1;
                    done_clr   = 1'b1;
                end else if (direct) begin
                    direct_next = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_next   = dwell_eff;
                state_next = stop ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (cnt > DWELL_WIDTH'(1)) begin
                    cnt_next = cnt - DWELL_WIDTH'(1);
                end else if (!last) begin
                    idx_next   = idx + IDX_WIDTH'(1);
                    load_next  = 1'b1;
                    state_next = ST_LOAD;
                end else if (loop) begin
                    idx_next   = '0;
                    load_next  = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            led          <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            cnt          <= cnt_next;
            m_chipselect <= load_next | direct_next;
            m_write_n    <= ~(load_next | direct_next);
            if (load_next)
                led <= pattern_data;
            else if (direct_next)
                led <= direct_data;
        end
    end

    assign m_address   = 2'b00;
    assign m_writedata = {{(32 - DATA_WIDTH){1'b0}}, led};
    assign busy        = (state != ST_IDLE);
    assign irq         = done & irq_en;

endmodule

// File: tb/tb_ledg_sequencer.sv
// Self-checking bench for ledg_sequencer: directed scenarios plus randomized
// runs, PIO write traces compared against a cycle-timing model of playback.
module tb_ledg_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        busy;
    logic        irq;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } pio_wr_t;

    pio_wr_t     got[$];
    logic [7:0]  pat_m [8];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          s;
    logic [31:0] rd;

    ledg_sequencer #(
        .DATA_WIDTH  (8),
        .DEPTH       (8),
        .DWELL_WIDTH (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .busy         (busy),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Record every PIO write with the cycle it is presented in.
    always @(negedge clk) begin
        if (!reset && m_chipselect && !m_write_n) begin
            got.push_back('{cyc, m_writedata});
            check("m_address", {30'b0, m_address}, 32'h0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One-cycle CSR write, called at a falling edge; returns at the next one.
    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        logic [3:0] a_v;
        a_v = a;
        s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
        if (a_v >= 4'd8) pat_m[a_v[2:0]] = d[7:0];
        @(negedge clk);
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
        #1;
        d = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic load_random_table();
        for (int i = 0; i < 8; i++) csr_wr(4'(8 + i), {24'h0, 8'($urandom)});
    endtask

    // Playback model: write k lands 1 + k*(1+max(dwell,1)) cycles after the
    // start write and carries table entry k modulo the effective length.
    task automatic check_trace(input string tag, input int st, input int dw, input int len, input int nwr);
        int l_eff, period;
        l_eff  = (len == 0 || len > 8) ? 8 : len;
        period = 1 + ((dw == 0) ? 1 : dw);
        check({tag, "_count"}, got.size(), nwr);
        for (int k = 0; k < nwr && k < got.size(); k++) begin
            check($sformatf("%s_cyc%0d", tag, k), got[k].cyc - st, 1 + k * period);
            check($sformatf("%s_data%0d", tag, k), got[k].data, {24'h0, pat_m[k % l_eff]});
        end
        got.delete();
    endtask

    initial begin
        reset = 1'b1; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
        for (int i = 0; i < 8; i++) pat_m[i] = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Reset state
        check("rst_cs", {31'b0, m_chipselect}, 0);
        check("rst_wn", {31'b0, m_write_n}, 1);
        check("rst_wd", m_writedata, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        csr_rd(4'd0, rd); check("rst_ctrl", rd, 0);
        csr_rd(4'd3, rd); check("rst_status", rd, 0);
        csr_rd(4'd1, rd); check("rst_dwell", rd, 0);
        csr_rd(4'd11, rd); check("rst_pat3", rd, 0);

        // Three-step one-shot; done W1C lands on the completing cycle
        csr_wr(4'd8, 32'h01); csr_wr(4'd9, 32'h02); csr_wr(4'd10, 32'h04);
        csr_wr(4'd2, 32'd3); csr_wr(4'd1, 32'd3); csr_wr(4'd0, 32'h0);
        csr_rd(4'd2, rd); check("length_rd", rd, 3);
        got.delete();
        s = cyc;
        csr_wr(4'd0, 32'h1);
        check("busy_after_start", {31'b0, busy}, 1);
        wait_until(s + 12);
        csr_wr(4'd3, 32'h1);
        check("basic_busy_end", {31'b0, busy}, 0);
        csr_rd(4'd3, rd); check("done_set_wins", rd, 32'h21);
        check("irq_masked", {31'b0, irq}, 0);
        idle(3);
        check_trace("basic", s, 3, 3, 3);
        csr_wr(4'd0, 32'h8);
        check("irq_enabled", {31'b0, irq}, 1);
        csr_wr(4'd3, 32'h1);
        csr_rd(4'd3, rd); check("done_w1c", rd & 32'h1, 0);
        check("irq_cleared", {31'b0, irq}, 0);

        // Looping run stopped mid-WAIT of the second pass
        s = cyc;
        csr_wr(4'd0, 32'hB);
        wait_until(s + 15);
        csr_wr(4'd0, 32'hE);
        check("stop_busy", {31'b0, busy}, 0);
        idle(10);
        check_trace("loop", s, 3, 3, 4);
        csr_rd(4'd3, rd); check("stop_no_done", rd & 32'h1, 0);
        check("stop_irq", {31'b0, irq}, 0);
        csr_rd(4'd0, rd); check("ctrl_rd", rd, 32'hA);

        // DWELL=0, LENGTH=0: full table, 2-cycle steps, index walks 0..7
        load_random_table();
        csr_wr(4'd1, 32'd0); csr_wr(4'd2, 32'd0); csr_wr(4'd0, 32'h8);
        s = cyc;
        csr_wr(4'd0, 32'h9);
        for (int j = 0; j < 16; j++) begin
            csr_rd(4'd3, rd);
            check($sformatf("idx_c%0d", j), (rd >> 4) & 32'h7, j / 2);
            @(negedge clk);
        end
        idle(2);
        check_trace("dwell0", s, 0, 0, 8);
        check("irq_done", {31'b0, irq}, 1);
        csr_wr(4'd3, 32'h1);

        // DIRECT while idle, then DIRECT and LENGTH while busy
        got.delete();
        s = cyc;
        csr_wr(4'd4, 32'hA5);
        idle(3);
        check("direct_count", got.size(), 1);
        if (got.size() > 0) begin
            check("direct_cyc", got[0].cyc - s, 1);
            check("direct_data", got[0].data, 32'h000000A5);
        end
        got.delete();
        csr_wr(4'd2, 32'd2); csr_wr(4'd1, 32'd2);
        s = cyc;
        csr_wr(4'd0, 32'h1);
        idle(2);
        csr_wr(4'd4, 32'h5A);
        csr_wr(4'd2, 32'd5);
        wait_until(s + 10);
        check_trace("busy_direct", s, 2, 2, 2);
        csr_rd(4'd2, rd); check("length_locked", rd, 2);

        // start|stop together starts nothing
        got.delete();
        csr_wr(4'd0, 32'h5);
        check("startstop_busy", {31'b0, busy}, 0);
        idle(4);
        check("startstop_writes", got.size(), 0);

        // Randomized one-shot runs with a redundant start while busy
        for (int r = 0; r < 6; r++) begin
            int dw, len, l_eff;
            dw  = $urandom_range(0, 4);
            len = $urandom_range(0, 15);
            l_eff = (len == 0 || len > 8) ? 8 : len;
            load_random_table();
            csr_wr(4'd1, dw); csr_wr(4'd2, len); csr_wr(4'd0, 32'h0);
            got.delete();
            s = cyc;
            csr_wr(4'd0, 32'h1);
            idle(1);
            csr_wr(4'd0, 32'h1);
            wait_until(s + l_eff * (1 + ((dw == 0) ? 1 : dw)) + 3);
            check_trace($sformatf("rand%0d", r), s, dw, len, l_eff);
            csr_rd(4'd3, rd);
            check($sformatf("rand%0d_status", r), rd, 32'h1 | ((l_eff - 1) << 4));
            check($sformatf("rand%0d_busy", r), {31'b0, busy}, 0);
        end

        // Reset asserted mid-WAIT
        csr_wr(4'd8, 32'h01); csr_wr(4'd1, 32'd3); csr_wr(4'd2, 32'd3);
        s = cyc;
        csr_wr(4'd0, 32'h9);
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_cs", {31'b0, m_chipselect}, 0);
        check("rstw_wn", {31'b0, m_write_n}, 1);
        check("rstw_busy", {31'b0, busy}, 0);
        check("rstw_irq", {31'b0, irq}, 0);
        reset = 1'b0;
        idle(1);
        csr_rd(4'd3, rd); check("rstw_status", rd, 0);
        csr_rd(4'd0, rd); check("rstw_ctrl", rd, 0);
        csr_rd(4'd1, rd); check("rstw_dwell", rd, 0);
        idle(6);
        got.delete();
        check("rstw_no_restart", {31'b0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ledg_sequencer.md
Name: ledg_sequencer

Overview:
- Avalon-MM controller between the Nios II data master and the 8-bit green-LED PIO.
- The CPU loads a small pattern table and a dwell time through a CSR slave. The block then plays the table out by issuing single-cycle writes to the PIO's s1 slave (data register, address 0).
- While the sequencer is idle, the CPU can also write the LEDs directly through the block. This makes the block the single owner of the PIO write port.

Parameters:
- DATA_WIDTH, 8, LED pattern width; matches PIO out_port width.
- DEPTH, 8, pattern table entries; power of 2, max 8.
- DWELL_WIDTH, 24, width of dwell counter in clk cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  4  CSR word address
- s_chipselect  in  1  CSR select
- s_write_n  in  1  CSR write strobe, active-low
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, combinational, zero wait states
- m_address  out  2  PIO address, always 0
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active-low
- m_writedata  out  32  PIO write data, {zeros, pattern}
- busy  out  1  sequence in progress
- irq  out  1  level interrupt = done & irq_en

Behaviour:
- Reset: all registers 0; FSM IDLE; m_chipselect=0; m_write_n=1; m_writedata=0; busy=0; irq=0. Reset mid-sequence aborts immediately.
- CSR write = s_chipselect & ~s_write_n. Register map (word addresses):
  - 0 CTRL, write: b0 start (W1, pulse), b1 loop, b2 stop (W1, pulse), b3 irq_en.
  - 0 CTRL, read: b0 busy, b1 loop, b3 irq_en.
  - 1 DWELL [DWELL_WIDTH-1:0].
  - 2 LENGTH [3:0]: entries played. Value 0 or >DEPTH is treated as DEPTH. Writes are ignored while busy.
  - 3 STATUS: b0 done (write-1-to-clear), b[6:4] current index (read-only).
  - 4 DIRECT [7:0]: when IDLE, issues one PIO write of this value in the next cycle. Ignored while busy.
  - 8..8+DEPTH-1: PATTERN[i] [7:0].
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states: IDLE, LOAD, WAIT.
  - IDLE: start -> LOAD with idx=0, done cleared. busy=1 from the cycle after the start write.
  - LOAD (1 cycle): m_chipselect=1, m_write_n=0, m_writedata={24'b0, PATTERN[idx]}. Load cnt = max(DWELL,1); go to WAIT.
  - WAIT: cnt decrements each cycle. On the cycle cnt reaches 1:
    - if idx < LENGTH-1: idx++ and go to LOAD;
    - else if loop: idx=0 and go to LOAD;
    - else: set done and go to IDLE.
- Step period = 1 + max(DWELL,1) cycles. The first PIO write occurs 1 cycle after the start write.
- Master outputs are registered. Outside LOAD and DIRECT cycles: m_chipselect=0, m_write_n=1. The PIO holds its last value.
- stop in LOAD or WAIT: go to IDLE next cycle. No further PIO write, done is not set, LEDs keep the last value.
- start while busy: ignored.
- start and stop in the same write: stop wins, so no sequence starts.
- PATTERN and DWELL writes while busy are allowed; they take effect at the next LOAD.
- Clearing loop while busy ends the sequence after the current pass.
- done W1C and a hardware set in the same cycle: the set wins.
- DIRECT and start in the same cycle cannot occur (different addresses).

Decomposition:
- Shared package ledg_seq_pkg holds:
  - register address constants (CTRL, DWELL, LENGTH, STATUS, DIRECT, PATTERN_BASE);
  - CTRL/STATUS bit positions;
  - FSM state encoding.
- One natural sub-module, ledg_seq_csr: register file, read mux, W1 pulses. The FSM and master port stay in the top level.

Test Plan:
- Reset asserted mid-WAIT -> next cycle m_chipselect=0, m_write_n=1, busy=0, STATUS=0, irq=0.
- PATTERN[0..2]=0x01,0x02,0x04; LENGTH=3; DWELL=3; loop=0; start -> PIO writes 0x01,0x02,0x04 at cycles 1, 5, 9 after start. Then done=1, busy=0; irq=1 only if irq_en=1.
- Same setup with loop=1 -> the 4th write is 0x01 at cycle 13. stop at cycle 15 -> no further writes, busy=0 at cycle 16, done=0.
- DWELL=0, LENGTH=0 (treated as 8) -> 8 writes spaced 2 cycles apart; STATUS index observed 0..7.
- DIRECT=0xA5 while idle -> one PIO write of 0x000000A5. DIRECT=0x5A while busy -> no PIO write from it.
- Write start|stop together -> busy stays 0, no PIO write. STATUS done W1C on the same cycle as a hardware set -> done reads 1.
